// File: rtl/osborne_kbd_matrix_pkg.sv
// Shared types and constants for the Osborne 1 keyboard matrix.
// The key coordinate is {hit, row, col}, and the matrix is indexed as row*8+col.
package osborne_pkg;

  localparam int unsigned KBD_ROWS = 8;
  localparam int unsigned KBD_COLS = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } kbd_coord_t;

  // Row-major view of the 64 key bits: m[row][col] == flat[row*8+col]
  typedef logic [KBD_ROWS-1:0][KBD_COLS-1:0] kbd_matrix_t;

  function automatic kbd_coord_t kc(input logic [2:0] r, input logic [2:0] c);
    return '{hit: 1'b1, row: r, col: c};
  endfunction

  localparam kbd_coord_t KEY_CTRL  = '{hit: 1'b1, row: 3'd0, col: 3'd2};
  localparam kbd_coord_t KEY_SHIFT = '{hit: 1'b1, row: 3'd0, col: 3'd3};

endpackage

// File: rtl/osborne_kbd_matrix_if.sv
// Key-event and row-scan signals between hps_io/CPU (master) and the matrix (slave).
interface osborne_kbd_matrix_if;
  logic [10:0] ps2_key;
  logic [7:0]  row_sel_n;
  logic [7:0]  col_n;
  logic        key_any;

  modport master (output ps2_key, output row_sel_n, input col_n, input key_any);
  modport slave  (input ps2_key, input row_sel_n, output col_n, output key_any);
endinterface

// File: rtl/osborne_kbd_matrix_map.sv
// Combinational lookup from {ext, scancode} (PS/2 set 2) to an Osborne matrix coordinate.
// Any code that is not listed returns hit=0, and the event is dropped.
module osborne_kbd_map
  import osborne_pkg::*;
(
  input  logic [8:0]  key,
  output kbd_coord_t  coord
);

  always_comb begin
    coord = '0;
    case (key)
      // row 0: control keys
      9'h076: coord = kc(3'd0, 3'd0);            // Esc
      9'h00D: coord = kc(3'd0, 3'd1);            // Tab
      9'h014, 9'h114: coord = KEY_CTRL;
      9'h012, 9'h059: coord = KEY_SHIFT;
      9'h05A, 9'h15A: coord = kc(3'd0, 3'd4);    // Return / keypad Enter
      9'h058: coord = kc(3'd0, 3'd5);            // Alpha lock
      9'h066: coord = kc(3'd0, 3'd6);            // Backspace
      9'h029: coord = kc(3'd0, 3'd7);            // Space
      // row 1: 1..8 (keypad 8 shares the '8' key)
      9'h016: coord = kc(3'd1, 3'd0);
      9'h01E: coord = kc(3'd1, 3'd1);
      9'h026: coord = kc(3'd1, 3'd2);
      9'h025: coord = kc(3'd1, 3'd3);
      9'h02E: coord = kc(3'd1, 3'd4);
      9'h036: coord = kc(3'd1, 3'd5);
      9'h03D: coord = kc(3'd1, 3'd6);
      9'h03E, 9'h075: coord = kc(3'd1, 3'd7);
      // row 2: 9 0 - = ` \ [ ]
      9'h046: coord = kc(3'd2, 3'd0);
      9'h045: coord = kc(3'd2, 3'd1);
      9'h04E: coord = kc(3'd2, 3'd2);
      9'h055: coord = kc(3'd2, 3'd3);
      9'h00E: coord = kc(3'd2, 3'd4);
      9'h05D: coord = kc(3'd2, 3'd5);
      9'h054: coord = kc(3'd2, 3'd6);
      9'h05B: coord = kc(3'd2, 3'd7);
      // row 3: Q W E R T Y U I
      9'h015: coord = kc(3'd3, 3'd0);
      9'h01D: coord = kc(3'd3, 3'd1);
      9'h024: coord = kc(3'd3, 3'd2);
      9'h02D: coord = kc(3'd3, 3'd3);
      9'h02C: coord = kc(3'd3, 3'd4);
      9'h035: coord = kc(3'd3, 3'd5);
      9'h03C: coord = kc(3'd3, 3'd6);
      9'h043: coord = kc(3'd3, 3'd7);
      // row 4: O P A S D F G H
      9'h044: coord = kc(3'd4, 3'd0);
      9'h04D: coord = kc(3'd4, 3'd1);
      9'h01C: coord = kc(3'd4, 3'd2);
      9'h01B: coord = kc(3'd4, 3'd3);
      9'h023: coord = kc(3'd4, 3'd4);
      9'h02B: coord = kc(3'd4, 3'd5);
      9'h034: coord = kc(3'd4, 3'd6);
      9'h033: coord = kc(3'd4, 3'd7);
      // row 5: J K L ; ' Z X C
      9'h03B: coord = kc(3'd5, 3'd0);
      9'h042: coord = kc(3'd5, 3'd1);
      9'h04B: coord = kc(3'd5, 3'd2);
      9'h04C: coord = kc(3'd5, 3'd3);
      9'h052: coord = kc(3'd5, 3'd4);
      9'h01A: coord = kc(3'd5, 3'd5);
      9'h022: coord = kc(3'd5, 3'd6);
      9'h021: coord = kc(3'd5, 3'd7);
      // row 6: V B N M , . /
      9'h02A: coord = kc(3'd6, 3'd0);
      9'h032: coord = kc(3'd6, 3'd1);
      9'h031: coord = kc(3'd6, 3'd2);
      9'h03A: coord = kc(3'd6, 3'd3);
      9'h041: coord = kc(3'd6, 3'd4);
      9'h049: coord = kc(3'd6, 3'd5);
      9'h04A: coord = kc(3'd6, 3'd6);
      // row 7: cursor keys (E0-prefixed)
      9'h175: coord = kc(3'd7, 3'd0);
      9'h172: coord = kc(3'd7, 3'd1);
      9'h16B: coord = kc(3'd7, 3'd2);
      9'h174: coord = kc(3'd7, 3'd3);
      default: coord = '0;
    endcase
  end

endmodule

// File: rtl/osborne_kbd_matrix.sv
// PS/2 key-event to Osborne 1 keyboard matrix, with keypress stretching.
// The pipeline is: edge detect -> map -> state update. A registered row-scan read runs alongside it.
module osborne_kbd_matrix
  import osborne_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 400000
) (
  input  logic                  clk,
  input  logic                  reset,
  osborne_kbd_matrix_if.slave   kbd
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  // Stage A
  logic       armed_q, armed_d;
  logic       tog_q, tog_d;
  logic       a_vld_q, a_vld_d;
  logic       a_press_q, a_press_d;
  logic [8:0] a_key_q, a_key_d;

  // Stage B
  kbd_coord_t a_coord;
  logic       b_vld_q, b_vld_d;
  logic       b_press_q, b_press_d;
  logic [2:0] b_row_q, b_row_d;
  logic [2:0] b_col_q, b_col_d;

  // Stage C
  kbd_matrix_t   key_down_q, key_down_d;
  kbd_matrix_t   key_latch_q, key_latch_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  // Output
  logic [7:0] col_n_q, col_n_d;
  logic       key_any_q, key_any_d;

  // The first cycle after reset only loads tog_q, so a toggle level that is already set is not seen as an event.
  always_comb begin
    armed_d   = 1'b1;
    tog_d     = kbd.ps2_key[10];
    a_vld_d   = armed_q && (kbd.ps2_key[10] != tog_q);
    a_press_d = kbd.ps2_key[9];
    a_key_d   = kbd.ps2_key[8:0];
  end

  osborne_kbd_map u_map (
    .key   (a_key_q),
    .coord (a_coord)
  );

  always_comb begin
    b_vld_d   = a_vld_q & a_coord.hit;
    b_press_d = a_press_q;
    b_row_d   = a_coord.row;
    b_col_d   = a_coord.col;
  end

  // A press in the same cycle as expiry wins. Otherwise expiry masks the latch with the next down state.
  always_comb begin
    key_down_d  = key_down_q;
    key_latch_d = key_latch_q;
    hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - CW'(1) : hold_cnt_q;
    if (b_vld_q) begin
      if (b_press_q) begin
        key_down_d[b_row_q][b_col_q]  = 1'b1;
        key_latch_d[b_row_q][b_col_q] = 1'b1;
        hold_cnt_d                    = CW'(HOLD_CYCLES);
      end else begin
        key_down_d[b_row_q][b_col_q] = 1'b0;
        if (hold_cnt_q == '0) key_latch_d[b_row_q][b_col_q] = 1'b0;
      end
    end
    if ((hold_cnt_q == CW'(1)) && !(b_vld_q && b_press_q))
      key_latch_d = key_latch_d & key_down_d;
  end

  always_comb begin
    logic [7:0] acc;
    acc = '0;
    for (int unsigned r = 0; r < KBD_ROWS; r++)
      acc = acc | (key_latch_q[r[2:0]] & {8{~kbd.row_sel_n[r[2:0]]}});
    col_n_d   = ~acc;
    key_any_d = |key_latch_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q     <= 1'b0;
      tog_q       <= 1'b0;
      a_vld_q     <= 1'b0;
      a_press_q   <= 1'b0;
      a_key_q     <= '0;
      b_vld_q     <= 1'b0;
      b_press_q   <= 1'b0;
      b_row_q     <= '0;
      b_col_q     <= '0;
      key_down_q  <= '0;
      key_latch_q <= '0;
      hold_cnt_q  <= '0;
      col_n_q     <= '1;
      key_any_q   <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      tog_q       <= tog_d;
      a_vld_q     <= a_vld_d;
      a_press_q   <= a_press_d;
      a_key_q     <= a_key_d;
      b_vld_q     <= b_vld_d;
      b_press_q   <= b_press_d;
      b_row_q     <= b_row_d;
      b_col_q     <= b_col_d;
      key_down_q  <= key_down_d;
      key_latch_q <= key_latch_d;
      hold_cnt_q  <= hold_cnt_d;
      col_n_q     <= col_n_d;
      key_any_q   <= key_any_d;
    end
  end

  assign kbd.col_n   = col_n_q;
  assign kbd.key_any = key_any_q;

endmodule

// File: doc/osborne_kbd_matrix.md
# osborne_kbd_matrix

Converts the 11-bit PS/2 key-event word from `hps_io` into the Osborne 1 keyboard matrix that the emulated Z80 scans. It sits inside the core between `hps_io`'s `ps2_key` output and the CPU's keyboard read path. `hps_io` writes key events; this block reads them and answers row scans. It also stretches short keypresses so that fast taps are never missed by the firmware scan loop.

## Interface
Parameters:
- `HOLD_CYCLES`, default 400000: minimum number of `clk` cycles a pressed key stays visible in the matrix after its latest press event.

Ports:
- `clk` in 1: core clock (`clk_sys` domain). One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high; clears all key state.
- `ps2_key` in 11: `[10]` toggle strobe (any change = new event), `[9]` 1 = press / 0 = release, `[8]` extended (E0) prefix, `[7:0]` scancode.
- `row_sel_n` in 8: active-low row selects from the CPU address lines. More than one row may be low at once.
- `col_n` out 8: active-low column data; bit c is low if any key in any selected row at column c is latched.
- `key_any` out 1: high while any key is latched (debug/LED use).

## Operation
- Stage A, edge detect:
  - `tog_q` registers `ps2_key[10]`; an event occurs when `ps2_key[10] != tog_q`.
  - The first cycle after reset release loads `tog_q` without generating an event, so a toggle level that is already set produces no event.
  - Also registers `{press, ext, code}` and the event flag.
- Stage B, map: `osborne_kbd_map` returns `{hit, row[2:0], col[2:0]}` from `{ext, code}`, registered. Events with `hit = 0` (unmapped, Pause, E1 sequences) are dropped.
- Stage C, state update. Vectors: `key_down[63:0]` (physical state), `key_latch[63:0]` (visible state), index = row*8+col. Global down-counter `hold_cnt` is `$clog2(HOLD_CYCLES+1)` bits.
  - Press: set `key_down[i]` and `key_latch[i]`; reload `hold_cnt` = HOLD_CYCLES. Repeat presses (typematic) are treated identically.
  - Release: clear `key_down[i]`. If `hold_cnt == 0`, also clear `key_latch[i]`; otherwise the latch stays set until expiry.
  - `hold_cnt` decrements each cycle while nonzero. On the cycle it transitions 1→0: `key_latch <= key_latch & key_down`.
  - Release of a key not down: no effect. Press of a key already down: latch stays set, timer reloads.
  - Press and expiry in the same cycle: the press wins, the timer reloads, and no expiry mask is applied that cycle.
  - Release and expiry in the same cycle: `key_latch <= key_latch & key_down_next` (the released key clears).
- Output: `col_n[c] = ~OR over r of (~row_sel_n[r] & key_latch[r*8+c])`, registered. All rows deselected gives `col_n = 8'hFF`.
- Reset (any time, including mid-hold): `key_down = 0`, `key_latch = 0`, `hold_cnt = 0`, `col_n = 8'hFF`, `key_any = 0`, pipeline valids cleared.

## Timing
- Event presented before edge N: `key_latch` updates at edge N+2; `col_n` reflects it at edge N+3, provided the row is selected.
- Row-select change before edge M: `col_n` is valid after edge M. Fixed 1-cycle latency, independent of event traffic.
- One event per cycle can be accepted; back-to-back toggles on consecutive cycles are all processed.
- Hold: a latched key whose release arrives early stays visible until exactly HOLD_CYCLES cycles after the last press update, then clears on the following edge.

## Structure
- Package `osborne_pkg`:
  - `kbd_coord_t` struct `{hit, row[2:0], col[2:0]}`.
  - Constants `KBD_ROWS = 8`, `KBD_COLS = 8`, and named coordinates for modifiers (`KEY_SHIFT`, `KEY_CTRL`).
- Sub-module `osborne_kbd_map`: purely combinational 9-bit → `kbd_coord_t` lookup (case table). It is separate so the matrix layout can change without touching the sequential logic.
- Top: three pipeline stages, the 64-bit state vectors, the hold counter, and the output OR-reduction.

## Test plan
- Reset with `ps2_key[10] = 1` held, then release reset → no event; `col_n = 8'hFF` for every `row_sel_n`, `key_any = 0`.
- Press 'A' (`ps2_key = {~t, 1, 0, 8'h1C}`) with its row selected → `col_n` bit for the mapped column low at edge N+3; other rows read `8'hFF`.
- Press then release 'A' 2 cycles apart, HOLD_CYCLES = 100 → key stays low for 100 cycles after the press update, then `col_n = 8'hFF`.
- Release after the hold has expired → `col_n` returns to `8'hFF` at edge N+3.
- Extended up-arrow `{1, 8'h75}` versus keypad-8 `{0, 8'h75}` → different coordinates per the map. Unmapped `8'h7E` → no state change.
- Two keys in different rows, both rows selected via `row_sel_n = 8'hFC` → both column bits low. Assert `reset` mid-hold → `col_n = 8'hFF` immediately after the asynchronous assert.
